// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: operands latched on start, DIGIT bits per clock, LSD first.
// Handshake: start is accepted only in IDLE or DONE; busy is high while digits are processed; done pulses one cycle with m/cout/ovf valid.
module serial_addsub #(
   parameter int WIDTH = 4,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] m,
   output logic             cout,
   output logic             ovf,
   output logic [1:0]       state_dbg
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT:0]         dsum;
   logic                   cin_msb;
   logic [WIDTH+DIGIT-1:0] r_cat;
   logic [WIDTH-1:0]       r_shift;
   logic                   last_digit;

   assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};

   // Carry into the top bit of the digit; on the last digit this is the carry into the word MSB.
   generate
      if (DIGIT == 1) begin : g_cin_1
         assign cin_msb = c_q;
      end else begin : g_cin_n
         logic [DIGIT-1:0] lo;
         assign lo      = {1'b0, a_q[DIGIT-2:0]} + {1'b0, b_q[DIGIT-2:0]}
                        + {{(DIGIT-1){1'b0}}, c_q};
         assign cin_msb = lo[DIGIT-1];
      end
   endgenerate

   assign r_cat      = {dsum[DIGIT-1:0], r_q} >> DIGIT;
   assign r_shift    = r_cat[WIDTH-1:0];
   assign last_digit = (cnt_q == CW'(N - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               c_d     = sub;
               r_d     = '0;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            r_d   = r_shift;
            c_d   = dsum[DIGIT];
            cnt_d = cnt_q + CW'(1);
            if (last_digit) begin
               state_d = S_DONE;
               m_d     = r_shift;
               cout_d  = dsum[DIGIT];
               ovf_d   = cin_msb ^ dsum[DIGIT];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         m_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy      = (state_q == S_BUSY);
   assign done      = (state_q == S_DONE);
   assign m         = m_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: a 4-bit/1-bit-digit instance and an 8-bit/2-bit-digit instance.
module tb_serial_addsub;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic       start4, sub4;
   logic [3:0] a4, b4, m4;
   logic       busy4, done4, cout4, ovf4;
   logic [1:0] st4;

   logic       start8, sub8;
   logic [7:0] a8, b8, m8;
   logic       busy8, done8, cout8, ovf8;
   logic [1:0] st8;

   serial_addsub #(.WIDTH(4), .DIGIT(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .m(m4), .cout(cout4), .ovf(ovf4), .state_dbg(st4)
   );

   serial_addsub #(.WIDTH(8), .DIGIT(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .m(m8), .cout(cout8), .ovf(ovf8), .state_dbg(st8)
   );

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic s);
      a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s);
      a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
      start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy4, done4, m4, cout4, ovf4, st4} !== 10'b0) begin
         failures++;
         $display("FAIL reset4: got busy=%b done=%b m=%h cout=%b ovf=%b st=%0d exp all 0",
                  busy4, done4, m4, cout4, ovf4, st4);
      end
      checks++;
      if ({busy8, done8, m8, cout8, ovf8, st8} !== 14'b0) begin
         failures++;
         $display("FAIL reset8: got busy=%b done=%b m=%h cout=%b ovf=%b st=%0d exp all 0",
                  busy8, done8, m8, cout8, ovf8, st8);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Add and the two subtract vectors, with cycle-accurate busy/done checks.
   task automatic test_addsub4;
      logic [3:0] va [3] = '{4'b0110, 4'b0110, 4'b1010};
      logic [3:0] vb [3] = '{4'b1010, 4'b1010, 4'b1111};
      logic       vs [3] = '{1'b0, 1'b1, 1'b1};
      logic [3:0] em [3] = '{4'b0000, 4'b1100, 4'b1011};
      logic       ec [3] = '{1'b1, 1'b0, 1'b0};
      logic       eo [3] = '{1'b0, 1'b1, 1'b0};
      for (int v = 0; v < 3; v++) begin
         drive4(va[v], vb[v], vs[v]);
         checks++;
         if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            failures++;
            $display("FAIL addsub4_start v%0d: got busy=%b done=%b exp busy=1 done=0", v, busy4, done4);
         end
         for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4) begin
               checks++;
               if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                  failures++;
                  $display("FAIL addsub4_busy v%0d c%0d: got busy=%b done=%b exp 1/0", v, i, busy4, done4);
               end
            end
         end
         checks++;
         if (done4 !== 1'b1 || busy4 !== 1'b0 || m4 !== em[v] || cout4 !== ec[v] || ovf4 !== eo[v]) begin
            failures++;
            $display("FAIL addsub4_result v%0d: got done=%b busy=%b m=%b cout=%b ovf=%b exp done=1 busy=0 m=%b cout=%b ovf=%b",
                     v, done4, busy4, m4, cout4, ovf4, em[v], ec[v], eo[v]);
         end
         @(posedge clk); #1;
         checks++;
         if (done4 !== 1'b0 || m4 !== em[v]) begin
            failures++;
            $display("FAIL addsub4_idle v%0d: got done=%b m=%b exp done=0 m=%b", v, done4, m4, em[v]);
         end
      end
   endtask

   // Inputs scrambled and start held high while busy: one op, latched operands.
   task automatic test_operand_hold4;
      int dcount = 0;
      drive4(4'b1011, 4'b0011, 1'b0);
      a4 = 4'b0111; b4 = 4'b0111; sub4 = 1'b1; start4 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (i == 4) start4 = 1'b0;
         if (done4 === 1'b1) dcount++;
      end
      checks++;
      if (m4 !== 4'b1110 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
         failures++;
         $display("FAIL hold4_result: got m=%b cout=%b ovf=%b exp m=1110 cout=0 ovf=0", m4, cout4, ovf4);
      end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done4 === 1'b1) dcount++;
      end
      checks++;
      if (dcount != 1 || busy4 !== 1'b0) begin
         failures++;
         $display("FAIL hold4_single_done: got dones=%0d busy=%b exp dones=1 busy=0", dcount, busy4);
      end
   endtask

   task automatic test_digit2;
      logic [7:0] va [2] = '{8'h7F, 8'h00};
      logic [7:0] vb [2] = '{8'h01, 8'h01};
      logic       vs [2] = '{1'b0, 1'b1};
      logic [7:0] em [2] = '{8'h80, 8'hFF};
      logic       ec [2] = '{1'b0, 1'b0};
      logic       eo [2] = '{1'b1, 1'b0};
      for (int v = 0; v < 2; v++) begin
         drive8(va[v], vb[v], vs[v]);
         for (int i = 1; i <= 4; i++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
               failures++;
               $display("FAIL digit2_busy v%0d c%0d: got busy=%b done=%b exp 1/0", v, i, busy8, done8);
            end
            @(posedge clk); #1;
         end
         checks++;
         if (done8 !== 1'b1 || busy8 !== 1'b0 || m8 !== em[v] || cout8 !== ec[v] || ovf8 !== eo[v]) begin
            failures++;
            $display("FAIL digit2_result v%0d: got done=%b busy=%b m=%h cout=%b ovf=%b exp done=1 busy=0 m=%h cout=%b ovf=%b",
                     v, done8, busy8, m8, cout8, ovf8, em[v], ec[v], eo[v]);
         end
         @(posedge clk); #1;
      end
   endtask

   // 0101+0010=0111, then 0100-0001=0011 with no borrow, started in the DONE cycle.
   task automatic test_back_to_back;
      drive4(4'b0101, 4'b0010, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (done4 !== 1'b1 || m4 !== 4'b0111) begin
         failures++;
         $display("FAIL b2b_first: got done=%b m=%b exp done=1 m=0111", done4, m4);
      end
      a4 = 4'b0100; b4 = 4'b0001; sub4 = 1'b1; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i < 5) begin
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0 || m4 !== 4'b0111) begin
               failures++;
               $display("FAIL b2b_hold c%0d: got busy=%b done=%b m=%b exp busy=1 done=0 m=0111",
                        i, busy4, done4, m4);
            end
            @(posedge clk); #1;
         end
      end
      checks++;
      if (done4 !== 1'b1 || m4 !== 4'b0011 || cout4 !== 1'b1 || ovf4 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second: got done=%b m=%b cout=%b ovf=%b exp done=1 m=0011 cout=1 ovf=0",
                  done4, m4, cout4, ovf4);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      int dcount = 0;
      drive4(4'b0110, 4'b1010, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy4, done4, m4, cout4, ovf4} !== 8'b0) begin
         failures++;
         $display("FAIL reset_mid: got busy=%b done=%b m=%b cout=%b ovf=%b exp all 0",
                  busy4, done4, m4, cout4, ovf4);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done4 === 1'b1 || busy4 === 1'b1) dcount++;
      end
      checks++;
      if (dcount != 0) begin
         failures++;
         $display("FAIL reset_mid_abort: got %0d busy/done cycles exp 0", dcount);
      end
      drive4(4'b0010, 4'b0001, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (done4 !== 1'b1 || m4 !== 4'b0011 || cout4 !== 1'b0 || ovf4 !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_after: got done=%b m=%b cout=%b ovf=%b exp done=1 m=0011 cout=0 ovf=0",
                  done4, m4, cout4, ovf4);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_addsub4();
      test_operand_hold4();
      test_digit2();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
